if_stage: RTL and testbench



---
 rtl/if_stage.sv | 140 ++++++++++++++
 tb/tb_if_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID register for the RV32IM pipeline.
// The PC issues word reads over a busy/ready handshake; stall and redirect are handled here.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_BOOT  | one idle cycle after reset release, no memory request
// S_FETCH | request at PC outstanding; completions load IF/ID
// S_HOLD  | fetched word parked in skid buffer while ID is stalled
// S_DRAIN | redirected while a request was in flight; finish and discard it
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSY,
  output logic [31:0] IFID_PC,
  output logic [31:0] IFID_INSTR,
  output logic        IFID_VALID,
  output logic [6:0]  OPCODE,
  output logic [2:0]  FUNC3,
  output logic [6:0]  FUNC7,
  output logic [4:0]  RS1,
  output logic [4:0]  RS2,
  output logic [4:0]  RD
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD, S_DRAIN} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_drain_addr;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_instr;
  logic [31:0] r_ifid_pc;
  logic [31:0] r_ifid_instr;
  logic        r_ifid_valid;

  logic [31:0] w_target;
  logic [31:0] w_pc_inc;

  // Masking keeps the low target bits architecturally dead without leaving them unread.
  assign w_target = BRANCH_TARGET & 32'hFFFF_FFFC;
  assign w_pc_inc = r_pc + 32'd4;

  assign IMEM_READ = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign IMEM_ADDR = (r_state == S_DRAIN) ? r_drain_addr : r_pc;

  assign IFID_PC    = r_ifid_pc;
  assign IFID_INSTR = r_ifid_instr;
  assign IFID_VALID = r_ifid_valid;

  assign OPCODE = r_ifid_instr[6:0];
  assign FUNC3  = r_ifid_instr[14:12];
  assign FUNC7  = r_ifid_instr[31:25];
  assign RS1    = r_ifid_instr[19:15];
  assign RS2    = r_ifid_instr[24:20];
  assign RD     = r_ifid_instr[11:7];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= S_BOOT;
      r_pc         <= RESET_PC;
      r_drain_addr <= RESET_PC;
      r_skid_pc    <= 32'd0;
      r_skid_instr <= 32'd0;
      r_ifid_pc    <= 32'd0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
    end else begin
      case (r_state)
        S_BOOT: begin
          if (BRANCH_TAKEN) r_pc <= w_target;
          r_state <= S_FETCH;
        end

        S_FETCH: begin
          if (BRANCH_TAKEN) begin
            r_pc         <= w_target;
            r_ifid_pc    <= 32'd0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
            r_skid_pc    <= 32'd0;
            r_skid_instr <= 32'd0;
            // An in-flight request must still complete on the bus before the new PC is issued.
            if (IMEM_BUSY) begin
              r_drain_addr <= r_pc;
              r_state      <= S_DRAIN;
            end
          end else if (!IMEM_BUSY) begin
            if (STALL) begin
              r_skid_pc    <= r_pc;
              r_skid_instr <= IMEM_READDATA;
              r_state      <= S_HOLD;
            end else begin
              r_ifid_pc    <= r_pc;
              r_ifid_instr <= IMEM_READDATA;
              r_ifid_valid <= 1'b1;
              r_pc         <= w_pc_inc;
            end
          end else if (!STALL) begin
            r_ifid_valid <= 1'b0;
          end
        end

        S_HOLD: begin
          if (BRANCH_TAKEN) begin
            r_pc         <= w_target;
            r_ifid_pc    <= 32'd0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
            r_skid_pc    <= 32'd0;
            r_skid_instr <= 32'd0;
            r_state      <= S_FETCH;
          end else if (!STALL) begin
            r_ifid_pc    <= r_skid_pc;
            r_ifid_instr <= r_skid_instr;
            r_ifid_valid <= 1'b1;
            r_pc         <= w_pc_inc;
            r_state      <= S_FETCH;
          end
        end

        S_DRAIN: begin
          if (BRANCH_TAKEN) r_pc <= w_target;
          if (!IMEM_BUSY) r_state <= S_FETCH;
        end

        default: r_state <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a memory model answers addr^A5A5A5A5, a scoreboard
// checks every instruction ID consumes (IFID_VALID=1, STALL=0) in order.
module tb_if_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] SALT = 32'hA5A5_A5A5;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        STALL = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [31:0] BRANCH_TARGET = 32'd0;
  logic        IMEM_READ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_READDATA;
  logic        IMEM_BUSY = 1'b0;
  logic [31:0] IFID_PC;
  logic [31:0] IFID_INSTR;
  logic        IFID_VALID;
  logic [6:0]  OPCODE;
  logic [2:0]  FUNC3;
  logic [6:0]  FUNC7;
  logic [4:0]  RS1;
  logic [4:0]  RS2;
  logic [4:0]  RD;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc_q[$];

  if_stage dut (
    .CLK(CLK), .RESET_N(RESET_N), .STALL(STALL),
    .BRANCH_TAKEN(BRANCH_TAKEN), .BRANCH_TARGET(BRANCH_TARGET),
    .IMEM_READ(IMEM_READ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_READDATA(IMEM_READDATA), .IMEM_BUSY(IMEM_BUSY),
    .IFID_PC(IFID_PC), .IFID_INSTR(IFID_INSTR), .IFID_VALID(IFID_VALID),
    .OPCODE(OPCODE), .FUNC3(FUNC3), .FUNC7(FUNC7),
    .RS1(RS1), .RS2(RS2), .RD(RD)
  );

  always #5 CLK = ~CLK;

  assign IMEM_READDATA = IMEM_ADDR ^ SALT;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: ID consumes whatever valid instruction sits in IF/ID when not stalled.
  always @(negedge CLK) begin
    if (RESET_N && IFID_VALID && !STALL) begin
      checks++;
      if (exp_pc_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got pc %h with nothing expected", IFID_PC);
      end else begin
        logic [31:0] e;
        e = exp_pc_q.pop_front();
        if (IFID_PC !== e || IFID_INSTR !== (e ^ SALT)) begin
          errors++;
          $display("FAIL sb_instr: got pc %h instr %h expected pc %h instr %h",
                   IFID_PC, IFID_INSTR, e, e ^ SALT);
        end
      end
    end
  end

  initial begin
    // reset state
    tick(); tick();
    chk("rst_read",  {31'd0, IMEM_READ}, 32'd0);
    chk("rst_addr",  IMEM_ADDR, 32'd0);
    chk("rst_pc",    IFID_PC, 32'd0);
    chk("rst_instr", IFID_INSTR, NOP);
    chk("rst_valid", {31'd0, IFID_VALID}, 32'd0);

    // consumption order expected across the whole run
    exp_pc_q.push_back(32'h0);
    exp_pc_q.push_back(32'h4);
    exp_pc_q.push_back(32'h8);
    exp_pc_q.push_back(32'hC);
    exp_pc_q.push_back(32'h100);
    exp_pc_q.push_back(32'h200);
    exp_pc_q.push_back(32'h204);
    exp_pc_q.push_back(32'hFFFF_FFFC);
    exp_pc_q.push_back(32'h0);

    RESET_N = 1'b1;
    chk("boot_read", {31'd0, IMEM_READ}, 32'd0);
    tick();
    chk("fetch_read", {31'd0, IMEM_READ}, 32'd1);
    chk("fetch_addr0", IMEM_ADDR, 32'd0);
    tick();
    chk("ifid_pc0", IFID_PC, 32'd0);
    chk("opcode", {25'd0, OPCODE}, 32'h25);
    chk("func3",  {29'd0, FUNC3},  32'h2);
    chk("func7",  {25'd0, FUNC7},  32'h52);
    chk("rd",     {27'd0, RD},     32'h0B);
    chk("rs1",    {27'd0, RS1},    32'h0B);
    chk("rs2",    {27'd0, RS2},    32'h1A);
    tick();
    chk("ifid_pc4", IFID_PC, 32'h4);

    // three wait states at PC=8
    IMEM_BUSY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("busy_addr",  IMEM_ADDR, 32'h8);
      chk("busy_read",  {31'd0, IMEM_READ}, 32'd1);
      chk("busy_bubble", {31'd0, IFID_VALID}, 32'd0);
    end
    IMEM_BUSY = 1'b0;
    tick();
    chk("after_busy_pc", IFID_PC, 32'h8);

    // stall while the PC=12 fetch completes
    STALL = 1'b1;
    tick();
    chk("hold_read", {31'd0, IMEM_READ}, 32'd0);
    chk("hold_ifid", IFID_PC, 32'h8);
    tick();
    chk("hold_ifid2", IFID_PC, 32'h8);
    STALL = 1'b0;
    tick();
    chk("unstall_pc", IFID_PC, 32'hC);

    // redirect to 0x103 with PC=16 in flight
    IMEM_BUSY = 1'b1;
    BRANCH_TAKEN = 1'b1;
    BRANCH_TARGET = 32'h103;
    tick();
    BRANCH_TAKEN = 1'b0;
    chk("drain_addr",  IMEM_ADDR, 32'h10);
    chk("drain_read",  {31'd0, IMEM_READ}, 32'd1);
    chk("drain_instr", IFID_INSTR, NOP);
    chk("drain_valid", {31'd0, IFID_VALID}, 32'd0);
    tick();
    IMEM_BUSY = 1'b0;
    tick();
    chk("target_addr", IMEM_ADDR, 32'h100);
    chk("target_bubble", {31'd0, IFID_VALID}, 32'd0);
    tick();
    chk("target_pc", IFID_PC, 32'h100);

    // redirect and stall together while in HOLD
    tick();
    STALL = 1'b1;
    tick();
    chk("hold2_read", {31'd0, IMEM_READ}, 32'd0);
    BRANCH_TAKEN = 1'b1;
    BRANCH_TARGET = 32'h200;
    tick();
    BRANCH_TAKEN = 1'b0;
    STALL = 1'b0;
    chk("redir_addr",  IMEM_ADDR, 32'h200);
    chk("redir_valid", {31'd0, IFID_VALID}, 32'd0);
    tick();
    chk("redir_pc", IFID_PC, 32'h200);
    tick();
    chk("redir_next", IFID_PC, 32'h204);

    // address wrap
    BRANCH_TAKEN = 1'b1;
    BRANCH_TARGET = 32'hFFFF_FFFF;
    tick();
    BRANCH_TAKEN = 1'b0;
    chk("wrap_addr0", IMEM_ADDR, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr", IMEM_ADDR, 32'h0);
    tick();

    // reset in the middle of a drain
    IMEM_BUSY = 1'b1;
    BRANCH_TAKEN = 1'b1;
    BRANCH_TARGET = 32'h300;
    tick();
    BRANCH_TAKEN = 1'b0;
    chk("drain2_addr", IMEM_ADDR, 32'h4);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("midrst_read", {31'd0, IMEM_READ}, 32'd0);
    chk("midrst_addr", IMEM_ADDR, 32'd0);
    chk("midrst_valid", {31'd0, IFID_VALID}, 32'd0);
    tick(); tick();

    chk("sb_leftover", exp_pc_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
